asmd_divider: RTL and testbench

//  Sequential restoring divider, the inverse partner of asmd_multiplier.

---
 rtl/asmd_divider_pkg.sv | 15 +
 rtl/asmd_divider_datapath.sv | 47 ++++
 rtl/asmd_divider.sv | 96 +++++++++
 tb/tb_asmd_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/asmd_divider_pkg.sv
// Shared ASMD controller definitions: state encodings and counter sizing.
// Used by asmd_divider and the asmd_multiplier controller.
package asmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ERR
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/asmd_divider_datapath.sv
// Restoring-divider datapath: partial remainder R, quotient shift register D,
// divisor latch and the trial subtractor, driven by load/step enables.
module asmd_divider_datapath #(
    parameter int word_length = 4
) (
    input  logic                       clk,
    input  logic                       load,
    input  logic                       step,
    input  logic [2*word_length-1:0]   dividend,
    input  logic [word_length-1:0]     divisor,
    output logic [word_length:0]       rem,
    output logic [word_length-1:0]     quo
);

    logic [word_length:0]   r_q;
    logic [word_length-1:0] d_q;
    logic [word_length-1:0] dvs_q;
    logic [word_length+1:0] r_sh;
    logic [word_length:0]   r_next;
    logic                   q_bit;

    always_comb begin
        r_sh  = {r_q, d_q[word_length-1]};
        q_bit = (r_sh >= {2'b00, dvs_q});
        if (q_bit) begin
            r_next = (word_length+1)'(r_sh - {2'b00, dvs_q});
        end else begin
            r_next = (word_length+1)'(r_sh);
        end
    end

    // The dividend's upper half preloads R so W steps yield the full quotient.
    always_ff @(posedge clk) begin
        if (load) begin
            r_q   <= {1'b0, dividend[2*word_length-1:word_length]};
            d_q   <= dividend[word_length-1:0];
            dvs_q <= divisor;
        end else if (step) begin
            r_q   <= r_next;
            d_q   <= {d_q[word_length-2:0], q_bit};
        end
    end

    assign rem = r_q;
    assign quo = d_q;

endmodule

// File: rtl/asmd_divider.sv
// Sequential restoring divider (2W / W) with start/ready handshake.
// Optional macro ASMD_DIVIDER_ERR_CHECK_EN enables the overflow/divide-by-zero pre-check.
module asmd_divider
    import asmd_pkg::*;
#(
    parameter int word_length = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2*word_length-1:0]   dividend,
    input  logic [word_length-1:0]     divisor,
    output logic [word_length-1:0]     quotient,
    output logic [word_length-1:0]     remainder,
    output logic                       ready,
    output logic                       err
);

    localparam int CW = cnt_width(word_length);

    state_t                 state;
    logic [CW-1:0]          count;
    logic                   load;
    logic                   step;
    logic [word_length:0]   dp_rem;
    logic [word_length-1:0] dp_quo;

    assign load = (state == S_IDLE) && start;
    assign step = (state == S_RUN) && (count != '0);

    asmd_divider_datapath #(
        .word_length(word_length)
    ) u_datapath (
        .clk      (clk),
        .load     (load),
        .step     (step),
        .dividend (dividend),
        .divisor  (divisor),
        .rem      (dp_rem),
        .quo      (dp_quo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            ready     <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= CW'(word_length);
                        ready <= 1'b0;
                        err   <= 1'b0;
`ifdef ASMD_DIVIDER_ERR_CHECK_EN
                        if ((divisor == '0) ||
                            (dividend[2*word_length-1:word_length] >= divisor)) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_RUN;
                        end
`else
                        state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    // One extra cycle at count==0 registers the finished result.
                    if (count == '0) begin
                        quotient  <= dp_quo;
                        remainder <= word_length'(dp_rem);
                        ready     <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                S_ERR: begin
                    quotient  <= '1;
                    remainder <= '0;
                    err       <= 1'b1;
                    ready     <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asmd_divider.sv
// Scoreboard bench for asmd_divider (W=4): driver pushes expected results,
// monitor checks them and the busy length whenever ready rises.
module tb_asmd_divider;

    localparam int W = 4;
    localparam int LAT_RUN = W + 1;
    localparam int LAT_ERR = 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           ready;
    logic           err;

    typedef struct {
        int unsigned q;
        int unsigned r;
        logic        e;
        logic        chk;
        int          lat;
        int unsigned a;
        int unsigned b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    asmd_divider #(.word_length(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .ready     (ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: samples 1ns after each rising edge.
    initial begin
        int   busy = 0;
        logic prev_ready = 1'b1;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("reset_ready", ready, 1);
                check("reset_quotient", quotient, 0);
                check("reset_remainder", remainder, 0);
                check("reset_err", err, 0);
                busy = 0;
            end else if (!ready) begin
                busy++;
            end else if (!prev_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("latency_%0d_%0d", e.a, e.b), busy, e.lat);
                    check($sformatf("err_%0d_%0d", e.a, e.b), err, e.e);
                    if (e.chk) begin
                        check($sformatf("quotient_%0d_%0d", e.a, e.b), quotient, e.q);
                        check($sformatf("remainder_%0d_%0d", e.a, e.b), remainder, e.r);
                    end
                end
                busy = 0;
            end
            prev_ready = ready;
        end
    end

    function automatic exp_t model(input int unsigned a, input int unsigned b);
        exp_t e;
        logic ok;
        e.a = a;
        e.b = b;
        ok  = (b != 0) && (a < b * (1 << W));
        e.q = ok ? a / b : 0;
        e.r = ok ? a % b : 0;
        e.e = 1'b0;
        e.chk = ok;
        e.lat = LAT_RUN;
`ifdef ASMD_DIVIDER_ERR_CHECK_EN
        if (!ok) begin
            e.q   = (1 << W) - 1;
            e.r   = 0;
            e.e   = 1'b1;
            e.chk = 1'b1;
            e.lat = LAT_ERR;
        end
`endif
        return e;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: ready still %0d after %0d cycles, expected 1", name, ready, n);
        end
    endtask

    task automatic issue(input int unsigned a, input int unsigned b, input logic push);
        @(negedge clk);
        if (push) sb.push_back(model(a, b));
        dividend = (2*W)'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic do_op(input int unsigned a, input int unsigned b);
        issue(a, b, 1'b1);
        wait_idle("op");
    endtask

    initial begin
        int unsigned a;
        int unsigned b;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_op(20, 4);
        do_op(100, 7);
        do_op(239, 15);
        do_op(0, 15);
        do_op(15, 1);
        do_op(14, 15);

        // start pulsed mid-run with new operands must be ignored
        issue(100, 7, 1'b1);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd9;
        divisor  = 4'd2;
        wait_idle("midrun");

        // reset two cycles into RUN aborts the operation
        issue(77, 9, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_op(20, 4);

`ifdef ASMD_DIVIDER_ERR_CHECK_EN
        do_op(30, 0);
        do_op(80, 5);
        do_op(20, 4);
        do_op(255, 15);
`endif

        for (int i = 0; i < 40; i++) begin
            b = $urandom_range(1, (1 << W) - 1);
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom_range(b * (1 << W), (1 << (2*W)) - 1);
                if ($urandom_range(0, 3) == 0) b = 0;
            end else begin
                a = $urandom_range(0, b * (1 << W) - 1);
            end
            if (b * (1 << W) > (1 << (2*W)) - 1 && a >= b * (1 << W)) a = 0;
            do_op(a, b);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
